pfft_frame_ctrl: RTL

PFFT_FRAME_CTRL -- requirements
Module: pfft_frame_ctrl

---
 rtl/pfft_frame_ctrl.sv | 165 ++++++++++++++++
 1 files changed

// File: rtl/pfft_frame_ctrl.sv
// Frame controller in front of a parallel FFT: 2-entry skid buffer that stamps
// tlast/tuser per frame, handles runtime length changes and counts FFT lane events.
module pfft_frame_ctrl #(
  parameter int unsigned MAX_FFT_LEN  = 2048,
  parameter int unsigned SAMP_PER_CLK = 2,
  parameter int unsigned SAMP_WID     = 32,
  parameter int unsigned TUSER        = 8,
  parameter int unsigned CNT_WID      = 16
) (
  input  logic                               clk,
  input  logic                               rst,
  input  logic [$clog2(MAX_FFT_LEN):0]       cfg_log2_len,
  input  logic                               cfg_load,
  output logic                               cfg_err,
  input  logic [SAMP_PER_CLK*SAMP_WID-1:0]   s_axis_tdata,
  input  logic                               s_axis_tvalid,
  output logic                               s_axis_tready,
  output logic [SAMP_PER_CLK*SAMP_WID-1:0]   m_axis_tdata,
  output logic                               m_axis_tvalid,
  output logic                               m_axis_tlast,
  output logic [TUSER-1:0]                   m_axis_tuser,
  input  logic                               m_axis_tready,
  input  logic [SAMP_PER_CLK-1:0]            event_tlast_unexpected,
  input  logic [SAMP_PER_CLK-1:0]            event_tlast_missing,
  input  logic [SAMP_PER_CLK-1:0]            event_fft_overflow,
  input  logic [SAMP_PER_CLK-1:0]            event_data_in_channel_halt,
  output logic [CNT_WID-1:0]                 tlast_err_cnt,
  output logic [CNT_WID-1:0]                 ovf_cnt,
  output logic [CNT_WID-1:0]                 halt_cnt,
  input  logic                               cnt_clr,
  output logic [TUSER-1:0]                   frame_cnt
);

  localparam int unsigned LOG2_MAX = $clog2(MAX_FFT_LEN);
  localparam int unsigned LOG2_SPC = $clog2(SAMP_PER_CLK);
  localparam int unsigned LW       = LOG2_MAX + 1;
  localparam int unsigned MIN_LOG2 = LOG2_SPC + 3;
  localparam int unsigned DW       = SAMP_PER_CLK * SAMP_WID;
  localparam int unsigned BW       = LOG2_MAX - LOG2_SPC;

  typedef struct packed {
    logic [DW-1:0]    data;
    logic             last;
    logic [TUSER-1:0] user;
  } beat_t;

  logic [LW-1:0]    act_log2;
  logic [LW-1:0]    pend_log2;
  logic [LW-1:0]    eff_log2;
  logic [BW-1:0]    beat_cnt;
  logic [BW:0]      beats_in_frame;
  logic [TUSER-1:0] seq;
  logic             in_last;
  logic             cfg_ok;
  logic             push;
  beat_t            in_beat;
  beat_t            out_q, out_n;
  beat_t            skid_q, skid_n;
  logic             out_valid, out_valid_n;
  logic             skid_valid, skid_valid_n;

  // A pending length is picked up whenever the beat counter sits at a frame boundary
  always_comb begin
    eff_log2       = (beat_cnt == '0) ? pend_log2 : act_log2;
    beats_in_frame = (BW+1)'(1) << (eff_log2 - LW'(LOG2_SPC));
    in_last        = ({1'b0, beat_cnt} == (beats_in_frame - (BW+1)'(1)));
    cfg_ok         = (cfg_log2_len >= LW'(MIN_LOG2)) && (cfg_log2_len <= LW'(LOG2_MAX));
    push           = s_axis_tvalid && s_axis_tready;
    in_beat        = '{data: s_axis_tdata, last: in_last, user: seq};
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      act_log2  <= LW'(LOG2_MAX);
      pend_log2 <= LW'(LOG2_MAX);
      beat_cnt  <= '0;
      seq       <= '0;
      cfg_err   <= 1'b0;
    end else begin
      act_log2 <= eff_log2;
      if (cfg_load) begin
        if (cfg_ok) pend_log2 <= cfg_log2_len;
        else        cfg_err   <= 1'b1;
      end
      if (push) begin
        if (in_last) begin
          beat_cnt <= '0;
          seq      <= seq + TUSER'(1);
        end else begin
          beat_cnt <= beat_cnt + BW'(1);
        end
      end
    end
  end

  // Skid buffer: output register fed from the skid entry first to keep order
  always_comb begin
    out_valid_n  = out_valid;
    out_n        = out_q;
    skid_valid_n = skid_valid;
    skid_n       = skid_q;
    if (!out_valid || m_axis_tready) begin
      if (skid_valid) begin
        out_valid_n  = 1'b1;
        out_n        = skid_q;
        skid_valid_n = push;
        if (push) skid_n = in_beat;
      end else begin
        out_valid_n = push;
        if (push) out_n = in_beat;
      end
    end else if (push) begin
      skid_valid_n = 1'b1;
      skid_n       = in_beat;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid     <= 1'b0;
      skid_valid    <= 1'b0;
      out_q         <= '0;
      skid_q        <= '0;
      s_axis_tready <= 1'b0;
    end else begin
      out_valid     <= out_valid_n;
      skid_valid    <= skid_valid_n;
      out_q         <= out_n;
      skid_q        <= skid_n;
      s_axis_tready <= !(out_valid_n && skid_valid_n);
    end
  end

  assign m_axis_tvalid = out_valid;
  assign m_axis_tdata  = out_q.data;
  assign m_axis_tlast  = out_q.last;
  assign m_axis_tuser  = out_q.user;

  always_ff @(posedge clk or posedge rst) begin
    if (rst)                                           frame_cnt <= '0;
    else if (out_valid && m_axis_tready && out_q.last) frame_cnt <= frame_cnt + TUSER'(1);
  end

  function automatic logic [CNT_WID-1:0] sat_inc(input logic [CNT_WID-1:0] c, input logic ev);
    return (ev && (c != '1)) ? c + CNT_WID'(1) : c;
  endfunction

  // One increment per cycle no matter how many lanes flag; clear has priority
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tlast_err_cnt <= '0;
      ovf_cnt       <= '0;
      halt_cnt      <= '0;
    end else if (cnt_clr) begin
      tlast_err_cnt <= '0;
      ovf_cnt       <= '0;
      halt_cnt      <= '0;
    end else begin
      tlast_err_cnt <= sat_inc(tlast_err_cnt, |(event_tlast_unexpected | event_tlast_missing));
      ovf_cnt       <= sat_inc(ovf_cnt, |event_fft_overflow);
      halt_cnt      <= sat_inc(halt_cnt, |event_data_in_channel_halt);
    end
  end

endmodule
